// File: rtl/rf_dbg_arbiter_if.sv
//------------------------------------------------------------------------------
// Module : rf_dbg_arbiter_if
// Debug-unit register access handshake (req/ack) toward rf_dbg_arbiter.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface rf_dbg_arbiter_if #(
    parameter int XLEN = 32
);
    logic            dbg_req_i;
    logic            dbg_we_i;
    logic [4:0]      dbg_addr_i;
    logic [XLEN-1:0] dbg_wdata_i;
    logic            dbg_ack_o;
    logic [XLEN-1:0] dbg_rdata_o;

    modport master (
        output dbg_req_i,
        output dbg_we_i,
        output dbg_addr_i,
        output dbg_wdata_i,
        input  dbg_ack_o,
        input  dbg_rdata_o
    );

    modport slave (
        input  dbg_req_i,
        input  dbg_we_i,
        input  dbg_addr_i,
        input  dbg_wdata_i,
        output dbg_ack_o,
        output dbg_rdata_o
    );
endinterface

`default_nettype wire

// File: rtl/rf_dbg_arbiter.sv
//------------------------------------------------------------------------------
// Module : rf_dbg_arbiter
// Shares the register file write port and read port 1 between the pipeline
// (always first) and debug accesses, with a starvation-driven stall request.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rf_dbg_arbiter #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    input  wire logic            wb_we_i,
    input  wire logic [4:0]      wb_dst_i,
    input  wire logic [XLEN-1:0] wb_r_i,
    input  wire logic [4:0]      pd_src1_i,
    input  wire logic            id_stall_i,
    rf_dbg_arbiter_if.slave      dbg,
    output logic                 dbg_stall_o,
    output logic                 rf_we_o,
    output logic [4:0]           rf_dst_o,
    output logic [XLEN-1:0]      rf_wdata_o,
    output logic [4:0]           rf_src1_o,
    input  wire logic [XLEN-1:0] rf_src1_q_i
);

    localparam int              c_CW    = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_CW-1:0] c_LIMIT = c_CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARB     = 2'd1,
        S_RD_WAIT = 2'd2,
        S_ACK     = 2'd3
    } state_t;

    state_t          r_state;
    logic            r_we;
    logic [4:0]      r_addr;
    logic [XLEN-1:0] r_wdata;
    logic [c_CW-1:0] r_cnt;
    logic            r_ack;
    logic [XLEN-1:0] r_rdata;
    logic            r_stall;
    logic            r_byp;
    logic [XLEN-1:0] r_byp_data;

    logic            w_arb;
    logic            w_addr_zero;
    logic            w_wr_grant;
    logic            w_rd_grant;

    assign w_arb       = (r_state == S_ARB);
    assign w_addr_zero = (r_addr == 5'd0);
    assign w_wr_grant  = w_arb && r_we  && !w_addr_zero && !wb_we_i;
    assign w_rd_grant  = w_arb && !r_we && !w_addr_zero && id_stall_i;

    // Port muxes stay combinational so the grant lands in the ARB cycle itself.
    always_comb begin
        rf_we_o    = wb_we_i;
        rf_dst_o   = wb_dst_i;
        rf_wdata_o = wb_r_i;
        rf_src1_o  = pd_src1_i;
        if (w_wr_grant) begin
            rf_we_o    = 1'b1;
            rf_dst_o   = r_addr;
            rf_wdata_o = r_wdata;
        end
        if (w_rd_grant) begin
            rf_src1_o = r_addr;
        end
    end

    assign dbg.dbg_ack_o   = r_ack;
    assign dbg.dbg_rdata_o = r_rdata;
    assign dbg_stall_o     = r_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_we       <= 1'b0;
            r_addr     <= 5'd0;
            r_wdata    <= '0;
            r_cnt      <= '0;
            r_ack      <= 1'b0;
            r_rdata    <= '0;
            r_stall    <= 1'b0;
            r_byp      <= 1'b0;
            r_byp_data <= '0;
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (dbg.dbg_req_i) begin
                        r_we    <= dbg.dbg_we_i;
                        r_addr  <= dbg.dbg_addr_i;
                        r_wdata <= dbg.dbg_wdata_i;
                        r_cnt   <= '0;
                        r_state <= S_ARB;
                    end
                end
                S_ARB: begin
                    if (w_addr_zero) begin
                        // x0 never touches the register file; reads return zero.
                        if (!r_we) begin
                            r_rdata <= '0;
                        end
                        r_ack   <= 1'b1;
                        r_state <= S_ACK;
                    end else if (w_wr_grant) begin
                        r_ack   <= 1'b1;
                        r_state <= S_ACK;
                    end else if (w_rd_grant) begin
                        // Same-cycle WB write to our index is newer than the array read.
                        r_byp      <= wb_we_i && (wb_dst_i == r_addr);
                        r_byp_data <= wb_r_i;
                        r_state    <= S_RD_WAIT;
                    end else begin
                        if (r_cnt != c_LIMIT) begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                        if (r_cnt >= (c_LIMIT - 1'b1)) begin
                            r_stall <= 1'b1;
                        end
                    end
                end
                S_RD_WAIT: begin
                    r_rdata <= r_byp ? r_byp_data : rf_src1_q_i;
                    r_ack   <= 1'b1;
                    r_state <= S_ACK;
                end
                S_ACK: begin
                    r_stall <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rf_dbg_arbiter.sv
//------------------------------------------------------------------------------
// Module : tb_rf_dbg_arbiter
// Directed bench for rf_dbg_arbiter with a transaction-level reference model.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_rf_dbg_arbiter;

    localparam int XLEN  = 32;
    localparam int LIMIT = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            wb_we;
    logic [4:0]      wb_dst;
    logic [31:0]     wb_r;
    logic [4:0]      pd_src1;
    logic            id_stall;
    logic            dbg_stall_o;
    logic            rf_we_o;
    logic [4:0]      rf_dst_o;
    logic [31:0]     rf_wdata_o;
    logic [4:0]      rf_src1_o;
    logic [31:0]     rf_q;

    rf_dbg_arbiter_if #(.XLEN(XLEN)) dif ();

    rf_dbg_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(LIMIT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wb_we_i     (wb_we),
        .wb_dst_i    (wb_dst),
        .wb_r_i      (wb_r),
        .pd_src1_i   (pd_src1),
        .id_stall_i  (id_stall),
        .dbg         (dif),
        .dbg_stall_o (dbg_stall_o),
        .rf_we_o     (rf_we_o),
        .rf_dst_o    (rf_dst_o),
        .rf_wdata_o  (rf_wdata_o),
        .rf_src1_o   (rf_src1_o),
        .rf_src1_q_i (rf_q)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Register file behind the arbiter: read-before-write, x0 hardwired.
    logic [31:0] rf_mem [32];
    bit          rf_loaded = 1'b0;
    always @(posedge clk) begin
        if (!rf_loaded) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= (i == 0) ? 32'h0 : 32'h1000_0000 + i;
            rf_loaded <= 1'b1;
        end else if (rf_we_o && rf_dst_o != 5'd0) begin
            rf_mem[rf_dst_o] <= rf_wdata_o;
        end
        rf_q <= rf_mem[rf_src1_o];
    end

    // Reference model: one outstanding transaction, its wait count and ack cycle.
    bit          m_txn = 1'b0, m_granted = 1'b0, m_we = 1'b0, m_loaded = 1'b0;
    logic [4:0]  m_addr = '0;
    logic [31:0] m_wdata = '0, m_rdata = '0;
    int          m_waits = 0, m_ack_cyc = 0;
    logic [31:0] m_mem [32];

    logic        arbit, m_grant, e_we, e_ack, e_stall;
    logic [4:0]  e_dst, e_src1;
    logic [31:0] e_wd;

    always_comb begin
        arbit   = rst_n && m_txn && !m_granted;
        m_grant = arbit && (m_addr == 5'd0 || (m_we ? !wb_we : id_stall));
        e_we    = wb_we;
        e_dst   = wb_dst;
        e_wd    = wb_r;
        e_src1  = pd_src1;
        if (arbit && m_addr != 5'd0 && m_we && !wb_we) begin
            e_we  = 1'b1;
            e_dst = m_addr;
            e_wd  = m_wdata;
        end
        if (arbit && m_addr != 5'd0 && !m_we && id_stall) e_src1 = m_addr;
        e_ack   = rst_n && m_txn && m_granted && (cyc == m_ack_cyc);
        e_stall = rst_n && m_txn && (m_waits >= LIMIT);
    end

    always @(posedge clk) begin
        if (!m_loaded) begin
            for (int i = 0; i < 32; i++) m_mem[i] <= (i == 0) ? 32'h0 : 32'h1000_0000 + i;
            m_loaded <= 1'b1;
        end else if (wb_we && wb_dst != 5'd0) begin
            m_mem[wb_dst] <= wb_r;
        end
        if (!rst_n) begin
            m_txn     <= 1'b0;
            m_granted <= 1'b0;
            m_waits   <= 0;
        end else if (m_txn) begin
            if (m_granted) begin
                if (cyc == m_ack_cyc) m_txn <= 1'b0;
            end else if (m_grant) begin
                m_granted <= 1'b1;
                if (m_we) begin
                    if (m_addr != 5'd0) m_mem[m_addr] <= m_wdata;
                    m_ack_cyc <= cyc + 1;
                end else begin
                    m_rdata   <= (m_addr == 5'd0) ? 32'h0 :
                                 (wb_we && wb_dst == m_addr) ? wb_r : m_mem[m_addr];
                    m_ack_cyc <= cyc + ((m_addr == 5'd0) ? 1 : 2);
                end
            end else begin
                m_waits <= m_waits + 1;
            end
        end else if (dif.dbg_req_i) begin
            m_txn     <= 1'b1;
            m_granted <= 1'b0;
            m_waits   <= 0;
            m_we      <= dif.dbg_we_i;
            m_addr    <= dif.dbg_addr_i;
            m_wdata   <= dif.dbg_wdata_i;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("rf_we",    32'(rf_we_o),     32'(e_we));
            chk("rf_dst",   32'(rf_dst_o),    32'(e_dst));
            chk("rf_wdata", rf_wdata_o,       e_wd);
            chk("rf_src1",  32'(rf_src1_o),   32'(e_src1));
            chk("ack",      32'(dif.dbg_ack_o), 32'(e_ack));
            chk("stall",    32'(dbg_stall_o), 32'(e_stall));
            if (e_ack && !m_we) chk("rdata", dif.dbg_rdata_o, m_rdata);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic we, input logic [4:0] addr, input logic [31:0] wd);
        dif.dbg_req_i   = 1'b1;
        dif.dbg_we_i    = we;
        dif.dbg_addr_i  = addr;
        dif.dbg_wdata_i = wd;
    endtask

    task automatic wait_ack(input int t0, output int lat, output logic [31:0] rd, output logic st);
        lat = -1;
        rd  = '0;
        st  = 1'b0;
        for (int i = 0; i < 40 && lat < 0; i++) begin
            step();
            if (dif.dbg_ack_o) begin
                lat = cyc - t0;
                rd  = dif.dbg_rdata_o;
                st  = dbg_stall_o;
            end
        end
        dif.dbg_req_i = 1'b0;
        if (lat < 0) begin
            checks++;
            failures++;
            $display("FAIL ack_timeout: got no ack expected ack within 40 cycles");
        end
        step();
    endtask

    int          t0, lat;
    logic [31:0] rd;
    logic        st;

    initial begin
        rst_n = 1'b1; wb_we = 1'b0; wb_dst = '0; wb_r = '0; pd_src1 = '0; id_stall = 1'b0;
        dif.dbg_req_i = 1'b0; dif.dbg_we_i = 1'b0; dif.dbg_addr_i = '0; dif.dbg_wdata_i = '0;
        #2 rst_n = 1'b0;
        step();
        step();
        chk_en = 1'b1;
        chk("reset_ack",   32'(dif.dbg_ack_o), 32'd0);
        chk("reset_stall", 32'(dbg_stall_o),   32'd0);
        chk("reset_rdata", dif.dbg_rdata_o,    32'd0);
        rst_n   = 1'b1;
        pd_src1 = 5'd17;
        step();

        // Debug write, WB idle.
        t0 = cyc; req(1'b1, 5'd5, 32'hDEAD_BEEF);
        step();
        chk("wr_grant_we",  32'(rf_we_o),  32'd1);
        chk("wr_grant_dst", 32'(rf_dst_o), 32'd5);
        wait_ack(t0, lat, rd, st);
        chk("wr_latency", lat, 32'd2);

        // Read back x5.
        id_stall = 1'b1;
        t0 = cyc; req(1'b0, 5'd5, 32'h0);
        wait_ack(t0, lat, rd, st);
        chk("rd_latency", lat, 32'd3);
        chk("rd_x5",      rd,  32'hDEAD_BEEF);
        id_stall = 1'b0;

        // WB busy for three cycles on the same index.
        t0 = cyc; req(1'b1, 5'd7, 32'h1);
        step();
        wb_we = 1'b1; wb_dst = 5'd7; wb_r = 32'h2;
        step(); step(); step();
        wb_we = 1'b0;
        wait_ack(t0, lat, rd, st);
        chk("busy_latency", lat, 32'd5);
        chk("busy_x7",      rf_mem[7], 32'h1);

        // Starvation on a read.
        pd_src1 = 5'd20;
        t0 = cyc; req(1'b0, 5'd3, 32'h0);
        for (int i = 0; i < 8; i++) step();
        chk("starve_pre",  32'(dbg_stall_o), 32'd0);
        step();
        chk("starve_on",   32'(dbg_stall_o), 32'd1);
        id_stall = 1'b1;
        wait_ack(t0, lat, rd, st);
        chk("starve_latency",  lat, 32'd11);
        chk("starve_ack_stall", 32'(st), 32'd1);
        chk("starve_rdata",    rd,  32'h1000_0003);
        chk("starve_off",      32'(dbg_stall_o), 32'd0);
        id_stall = 1'b0;

        // Read bypass: grant coincides with WB writing the same index.
        t0 = cyc; req(1'b0, 5'd9, 32'h0);
        step();
        id_stall = 1'b1; wb_we = 1'b1; wb_dst = 5'd9; wb_r = 32'h55;
        step();
        id_stall = 1'b0; wb_we = 1'b0;
        wait_ack(t0, lat, rd, st);
        chk("byp_latency", lat, 32'd3);
        chk("byp_rdata",   rd,  32'h55);

        // Reset while a write is pending in arbitration.
        wb_we = 1'b1; wb_dst = 5'd13; wb_r = 32'h13;
        req(1'b1, 5'd12, 32'h0000_AAAA);
        step();
        step();
        #2;
        rst_n = 1'b0; wb_we = 1'b0; dif.dbg_req_i = 1'b0;
        step();
        chk("rst_ack",   32'(dif.dbg_ack_o), 32'd0);
        chk("rst_stall", 32'(dbg_stall_o),   32'd0);
        chk("rst_rdata", dif.dbg_rdata_o,    32'd0);
        chk("rst_rf_we", 32'(rf_we_o),       32'd0);
        rst_n = 1'b1;
        step();
        chk("rst_no_write", rf_mem[12], 32'h1000_000C);
        t0 = cyc; req(1'b1, 5'd12, 32'h1234);
        wait_ack(t0, lat, rd, st);
        chk("post_rst_latency", lat, 32'd2);
        chk("post_rst_x12",     rf_mem[12], 32'h1234);

        // x0 write: pipeline keeps the port.
        wb_we = 1'b1; wb_dst = 5'd4; wb_r = 32'h44;
        t0 = cyc; req(1'b1, 5'd0, 32'hFFFF_FFFF);
        step();
        chk("x0w_dst",   32'(rf_dst_o), 32'd4);
        chk("x0w_wdata", rf_wdata_o,    32'h44);
        wait_ack(t0, lat, rd, st);
        chk("x0w_latency", lat, 32'd2);
        wb_we = 1'b0;

        // x0 read.
        t0 = cyc; req(1'b0, 5'd0, 32'h0);
        wait_ack(t0, lat, rd, st);
        chk("x0r_latency", lat, 32'd2);
        chk("x0r_rdata",   rd,  32'h0);

        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rf_dbg_arbiter.md
# rf_dbg_arbiter

Arbiter that shares the integer register file's write port and read port 1 between the pipeline (WB stage writes, PD/ID source-1 reads) and the debug unit's register access requests. The block sits between the core pipeline and `int_rf`. The pipeline always has priority. A debug request that waits too long raises a hold request so that the debug access can complete. The block contains a small state machine, a starvation counter and a req/ack handshake toward the debug unit.

## Interface
- `XLEN`, 32, register data width
- `STARVE_LIMIT`, 8, number of ARB cycles without a grant before `dbg_stall_o` asserts (must be ≥1)
- `clk` in 1: core clock, rising edge
- `rst_n` in 1: asynchronous active-low reset
- `wb_we_i` in 1: WB stage register write enable
- `wb_dst_i` in 5: WB destination index
- `wb_r_i` in XLEN: WB write data
- `pd_src1_i` in 5: pipeline source-1 read index
- `id_stall_i` in 1: ID stalled, so pipeline read port 1 is unused this cycle
- `dbg_req_i` in 1: debug access request, held high until ack
- `dbg_we_i` in 1: 1 = write, 0 = read
- `dbg_addr_i` in 5: debug register index
- `dbg_wdata_i` in XLEN: debug write data
- `dbg_ack_o` out 1: one-cycle completion pulse
- `dbg_rdata_o` out XLEN: read result, valid while `dbg_ack_o`=1
- `dbg_stall_o` out 1: request for the pipeline to hold WB writes and ID
- `rf_we_o` out 1: register file write enable
- `rf_dst_o` out 5: register file write index
- `rf_wdata_o` out XLEN: register file write data
- `rf_src1_o` out 5: register file read-port-1 index
- `rf_src1_q_i` in XLEN: read-port-1 data, valid one cycle after the index is presented

## Operation
- **States:** IDLE, ARB, RD_WAIT, ACK.
- **IDLE**
  - On `dbg_req_i`=1, latch `dbg_we_i`, `dbg_addr_i` and `dbg_wdata_i`.
  - Clear the starvation counter and go to ARB.
- **ARB, write**
  - If `wb_we_i`=0, grant the write port for this cycle: `rf_we_o`=1, `rf_dst_o`=latched address, `rf_wdata_o`=latched data. Then go to ACK.
  - Otherwise stay in ARB and increment the counter.
- **ARB, read**
  - If `id_stall_i`=1, grant the read port: `rf_src1_o`=latched address. Then go to RD_WAIT.
  - Otherwise stay in ARB and increment the counter.
- **Register x0**
  - A write to index 0 goes directly from ARB to ACK with `rf_we_o` following the pipeline; no register file write occurs.
  - A read of index 0 goes directly to ACK with `dbg_rdata_o`=0.
- **RD_WAIT**
  - Capture `rf_src1_q_i` into `dbg_rdata_o`.
  - Bypass: if `wb_we_i`=1 and `wb_dst_i`=latched address, with `wb_dst_i`≠0, in the grant cycle, capture that cycle's `wb_r_i` instead.
  - Go to ACK.
- **ACK**
  - `dbg_ack_o`=1 for exactly one cycle, then go to IDLE.
  - `dbg_req_i` is ignored in ACK. A new request is accepted in IDLE from the following cycle.
- **Starvation**
  - The counter is clog2(STARVE_LIMIT+1) bits wide and saturates at STARVE_LIMIT.
  - `dbg_stall_o` is registered. It asserts on the clock edge where the counter reaches STARVE_LIMIT and stays asserted through RD_WAIT and ACK.
  - It deasserts on the edge leaving ACK.
- **Pass-through when not granted:** `rf_we_o`=`wb_we_i`, `rf_dst_o`=`wb_dst_i`, `rf_wdata_o`=`wb_r_i`, `rf_src1_o`=`pd_src1_i`.
- **Simultaneous events:** a pipeline write in the same cycle as a pending debug write always wins; the debug write waits. No write is ever dropped or merged.
- **Debug unit obligation:** `dbg_req_i` must not be withdrawn before ack. If it is withdrawn, the latched transaction still completes.

## Timing
- **Reset values:** state IDLE, `dbg_ack_o`=0, `dbg_rdata_o`=0, `dbg_stall_o`=0, counter 0.
  - The `rf_*` outputs pass the pipeline inputs through.
  - Reset asserted mid-transaction aborts it: no register file write, no ack.
- **Write latency:** `dbg_req_i` rises in cycle 0 → ARB in cycle 1 (register file written at the end of cycle 1 if WB is idle) → `dbg_ack_o` in cycle 2.
- **Read latency:** req in cycle 0 → ARB in cycle 1 (granted if `id_stall_i`) → RD_WAIT in cycle 2 → ack with data in cycle 3.
- Each cycle without a grant adds one cycle to either latency.
- Grant decisions in ARB are combinational on `wb_we_i`/`id_stall_i`. All state and outputs other than the `rf_*` muxes are registered.

## Test plan
- **Debug write, WB idle:** write x5=0xDEADBEEF → ack 2 cycles after req; `rf_we_o`=1, `rf_dst_o`=5 for one cycle; a subsequent debug read of x5 returns 0xDEADBEEF.
- **WB busy:** debug write x7=0x1 while `wb_we_i`=1 for 3 cycles writing x7=0x2 → pipeline writes pass unchanged; debug write lands after them; final x7=0x1; ack 5 cycles after req.
- **Starvation:** STARVE_LIMIT=8, read x3 with `id_stall_i`=0 indefinitely → `dbg_stall_o`=1 after 8 ARB cycles; TB raises `id_stall_i` → ack 2 cycles later; `dbg_stall_o` drops after ack.
- **Read bypass:** debug read x9 granted in the same cycle WB writes x9=0x55 → `dbg_rdata_o`=0x55.
- **x0 accesses:** write x0=0xFFFFFFFF gives ack with `rf_we_o` never asserted by debug; read x0 returns 0.
- **Reset mid-operation:** `rst_n` low while in ARB with a pending write → no write, no ack, all outputs at reset values; a new request after reset completes normally.
